// File: rtl/lane_bank_pkg.sv
// ---------------------------------------------------------------------------
// flippy_pkg : shared types and constants for the lane_bank falling-target game.
//   lane_state_t : per-lane state (IDLE, FALL, OVER)
//   LANES        : number of lanes in the bank
//   LFSR_TAPS    : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of a
//                  left-shifting Fibonacci register)
//   rol8()       : 8-bit rotate-left helper
//   lfsr_next()  : one Fibonacci step of the target LFSR
//   lane_rot()   : rotate amount applied to the LFSR for each lane's load
// Optional feature macro used by the design: LANE_SPEEDUP_EN
// ---------------------------------------------------------------------------
package flippy_pkg;

    localparam int LANES = 3;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        OVER = 2'd2
    } lane_state_t;

    function automatic logic [7:0] rol8(input logic [7:0] v, input int unsigned n);
        logic [15:0] w;
        w = {v, v} << n[2:0];
        return w[15:8];
    endfunction

    // Feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic int unsigned lane_rot(input int lane);
        case (lane)
            0:       return 32'd0;
            1:       return 32'd3;
            default: return 32'd5;
        endcase
    endfunction

endpackage

// File: rtl/lane_bank_if.sv
// ---------------------------------------------------------------------------
// lane_bank_if : game-side bus of the lane bank.
//   reset_signal [2:0]  per-lane restart request (level)
//   tick                fall-step strobe
//   switches     [7:0]  player switch value
//   game_over    [2:0]  per-lane OVER level
//   correct      [2:0]  per-lane match pulse
//   lane_value   [23:0] targets, lane i at [8i+7:8i]
//   lane_height  [11:0] heights, lane i at [4i+3:4i]
// master: game controller / testbench side; slave: lane_bank side.
// ---------------------------------------------------------------------------
interface lane_bank_if;
    logic [2:0]  reset_signal;
    logic        tick;
    logic [7:0]  switches;
    logic [2:0]  game_over;
    logic [2:0]  correct;
    logic [23:0] lane_value;
    logic [11:0] lane_height;

    modport master (
        output reset_signal, tick, switches,
        input  game_over, correct, lane_value, lane_height
    );

    modport slave (
        input  reset_signal, tick, switches,
        output game_over, correct, lane_value, lane_height
    );
endinterface

// File: rtl/lane_bank_lane_unit.sv
// ---------------------------------------------------------------------------
// lane_unit : one lane of the bank -- state machine, target, height, fall
// phase and (optionally) hit counter. All outputs are registered.
//   clock, reset    rising-edge clock, synchronous active-high reset
//   restart_i       restart request for this lane
//   tick_i          fall-step strobe
//   switches_i      player switch value
//   lfsr_i          shared LFSR value (rotated here by ROT)
//   game_over_o     high while in OVER
//   correct_o       one-cycle pulse after a match
//   target_o        current target
//   height_o        current height
// Macro LANE_SPEEDUP_EN adds a saturating hit counter; at 4+ hits every
// tick advances the lane instead of every second tick.
// ---------------------------------------------------------------------------
module lane_unit
    import flippy_pkg::*;
#(
    parameter int          HEIGHT_MAX = 9,
    parameter int unsigned ROT        = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart_i,
    input  logic       tick_i,
    input  logic [7:0] switches_i,
    input  logic [7:0] lfsr_i,
    output logic       game_over_o,
    output logic       correct_o,
    output logic [7:0] target_o,
    output logic [3:0] height_o
);

    localparam logic [4:0] HMAX_C = 5'(HEIGHT_MAX);

    lane_state_t state_q;
    logic [7:0]  target_q;
    logic [3:0]  height_q;
    logic        phase_q;
    logic        game_over_q;
    logic        correct_q;
`ifdef LANE_SPEEDUP_EN
    logic [2:0]  hits_q;
`endif

    logic [7:0]  rot_s;
    logic [7:0]  load_value_s;
    logic        match_s;
    logic        advance_s;
    logic [4:0]  height_inc_s;

    // New target: rotated LFSR, with bit 0 flipped if it would match right away.
    always_comb begin
        rot_s = rol8(lfsr_i, ROT);
        if (rot_s == switches_i) begin
            load_value_s = rot_s ^ 8'h01;
        end else begin
            load_value_s = rot_s;
        end
    end

    // Match detection, advance strobe and the incremented height.
    always_comb begin
        match_s      = (state_q == FALL) && (switches_i == target_q);
        height_inc_s = {1'b0, height_q} + 5'd1;
`ifdef LANE_SPEEDUP_EN
        advance_s    = tick_i && (phase_q || (hits_q >= 3'd4));
`else
        advance_s    = tick_i && phase_q;
`endif
    end

    // Lane state machine with registered outputs; restart beats match.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= 8'h00;
            height_q    <= 4'd0;
            phase_q     <= 1'b0;
            game_over_q <= 1'b0;
            correct_q   <= 1'b0;
`ifdef LANE_SPEEDUP_EN
            hits_q      <= 3'd0;
`endif
        end else begin
            correct_q <= 1'b0;
            if (restart_i) begin
                state_q     <= FALL;
                target_q    <= load_value_s;
                height_q    <= 4'd0;
                phase_q     <= 1'b0;
                game_over_q <= 1'b0;
`ifdef LANE_SPEEDUP_EN
                hits_q      <= 3'd0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    FALL: begin
                        if (match_s) begin
                            // A match also wins over a bottom-reaching advance.
                            correct_q <= 1'b1;
                            target_q  <= load_value_s;
                            height_q  <= 4'd0;
                            phase_q   <= 1'b0;
`ifdef LANE_SPEEDUP_EN
                            if (hits_q != 3'd7) begin
                                hits_q <= hits_q + 3'd1;
                            end
`endif
                        end else if (tick_i) begin
                            phase_q <= ~phase_q;
                            if (advance_s) begin
                                height_q <= height_inc_s[3:0];
                                if (height_inc_s == HMAX_C) begin
                                    state_q     <= OVER;
                                    game_over_q <= 1'b1;
                                end
                            end
                        end
                    end
                    OVER: begin
                        state_q <= OVER;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign game_over_o = game_over_q;
    assign correct_o   = correct_q;
    assign target_o    = target_q;
    assign height_o    = height_q;

endmodule

// File: rtl/lane_bank.sv
// ---------------------------------------------------------------------------
// lane_bank : three falling-target lanes sharing one 8-bit Fibonacci LFSR.
//   clock  rising-edge clock
//   reset  synchronous active-high reset (LFSR reloads SEED, lanes go IDLE)
//   bus    lane_bank_if.slave -- reset_signal/tick/switches in,
//          game_over/correct/lane_value/lane_height out
// Parameters: HEIGHT_MAX (<= 15), SEED (non-zero LFSR reset value).
// Optional feature macro: LANE_SPEEDUP_EN (handled inside lane_unit).
// ---------------------------------------------------------------------------
module lane_bank
    import flippy_pkg::*;
#(
    parameter int         HEIGHT_MAX = 9,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    lane_bank_if.slave  bus
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // LFSR steps on every clock regardless of lane activity.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // Shared LFSR register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_unit #(
            .HEIGHT_MAX (HEIGHT_MAX),
            .ROT        (lane_rot(i))
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .restart_i   (bus.reset_signal[i]),
            .tick_i      (bus.tick),
            .switches_i  (bus.switches),
            .lfsr_i      (lfsr_q),
            .game_over_o (bus.game_over[i]),
            .correct_o   (bus.correct[i]),
            .target_o    (bus.lane_value[8*i +: 8]),
            .height_o    (bus.lane_height[4*i +: 4])
        );
    end

endmodule

// File: tb/tb_lane_bank.sv
// ---------------------------------------------------------------------------
// tb_lane_bank : self-checking bench for lane_bank. A behavioural model of
// the game rules is advanced on every rising edge and compared against the
// DUT on every falling edge; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_lane_bank;

    localparam int         HMAX = 9;
    localparam logic [7:0] SEED = 8'hA5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lane_bank_if bif ();

    lane_bank #(.HEIGHT_MAX(HMAX), .SEED(SEED)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    bit         m_valid = 1'b0;
    logic [7:0] m_lfsr;
    int         m_state [3];   // 0 idle, 1 falling, 2 over
    int         m_h     [3];
    logic [7:0] m_t     [3];
    int         m_ticks [3];   // ticks seen while falling since last load
    int         m_hits  [3];
    logic [2:0] m_go, m_cor;

    function automatic logic [7:0] m_rot(input logic [7:0] v, input int lane);
        case (lane)
            0:       return v;
            1:       return {v[4:0], v[7:5]};
            default: return {v[2:0], v[7:3]};
        endcase
    endfunction

    function automatic logic [7:0] m_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clock) begin
        logic [7:0] old;
        logic [7:0] nt;
        bit speed;
        if (reset) begin
            m_valid = 1'b1;
            m_lfsr  = SEED;
            m_go    = 3'b000;
            m_cor   = 3'b000;
            for (int i = 0; i < 3; i++) begin
                m_state[i] = 0; m_h[i] = 0; m_t[i] = 8'h00;
                m_ticks[i] = 0; m_hits[i] = 0;
            end
        end else if (m_valid) begin
            old    = m_lfsr;
            m_lfsr = m_step(old);
            for (int i = 0; i < 3; i++) begin
                nt = m_rot(old, i);
                if (nt == bif.switches) nt[0] = ~nt[0];
                m_cor[i] = 1'b0;
                if (bif.reset_signal[i]) begin
                    m_state[i] = 1; m_h[i] = 0; m_t[i] = nt;
                    m_ticks[i] = 0; m_hits[i] = 0; m_go[i] = 1'b0;
                end else if (m_state[i] == 1) begin
                    if (bif.switches == m_t[i]) begin
                        m_cor[i] = 1'b1; m_h[i] = 0; m_t[i] = nt; m_ticks[i] = 0;
                        if (m_hits[i] < 7) m_hits[i]++;
                    end else if (bif.tick) begin
                        m_ticks[i]++;
`ifdef LANE_SPEEDUP_EN
                        speed = (m_hits[i] >= 4);
`else
                        speed = 1'b0;
`endif
                        if (speed || (m_ticks[i] % 2 == 0)) begin
                            m_h[i]++;
                            if (m_h[i] == HMAX) begin
                                m_state[i] = 2; m_go[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_game_over", 32'(bif.game_over), 32'(m_go));
            chk("model_correct",   32'(bif.correct),   32'(m_cor));
            chk("model_value",     32'(bif.lane_value), {8'h00, m_t[2], m_t[1], m_t[0]});
            chk("model_height",    32'(bif.lane_height),
                32'({4'(m_h[2]), 4'(m_h[1]), 4'(m_h[0])}));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bif.reset_signal = 3'b000;
        bif.tick = 1'b0;
        bif.switches = 8'h00;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    logic [7:0] sw;

    initial begin
        bif.reset_signal = 3'b000;
        bif.tick = 1'b0;
        bif.switches = 8'h00;
        repeat (3) cyc();
        chk("reset_value",     32'(bif.lane_value), 32'd0);
        chk("reset_height",    32'(bif.lane_height), 32'd0);
        chk("reset_game_over", 32'(bif.game_over), 32'd0);
        chk("reset_correct",   32'(bif.correct), 32'd0);

        // All lanes load on the first cycle after reset.
        reset = 1'b0;
        bif.reset_signal = 3'b111;
        cyc();
        bif.reset_signal = 3'b000;
        chk("seed_load_value", 32'(bif.lane_value), 32'h00B42DA5);
        chk("seed_load_height", 32'(bif.lane_height), 32'd0);

        // Lane 1 match.
        sw = m_t[1];
        bif.switches = sw;
        cyc();
        chk("l1_correct_pulse", 32'(bif.correct), 32'd2);
        chk("l1_height_clear", 32'(bif.lane_height[7:4]), 32'd0);
        chk("l1_new_target_differs", 32'(bif.lane_value[15:8] != sw), 32'd1);
        cyc();
        chk("l1_correct_one_cycle", 32'(bif.correct), 32'd0);

        // Restart and match on lane 2 together: restart wins.
        sw = m_t[2];
        bif.switches = sw;
        bif.reset_signal = 3'b100;
        cyc();
        bif.reset_signal = 3'b000;
        chk("l2_restart_no_correct", 32'(bif.correct[2]), 32'd0);
        chk("l2_restart_height", 32'(bif.lane_height[11:8]), 32'd0);
        chk("l2_restart_target_differs", 32'(bif.lane_value[23:16] != sw), 32'd1);
        cyc();
        chk("l2_restart_no_late_correct", 32'(bif.correct[2]), 32'd0);

        // Lane 0 falls to the bottom after 18 ticks.
        do_reset();
        bif.reset_signal = 3'b001;
        cyc();
        bif.reset_signal = 3'b000;
        bif.tick = 1'b1;
        repeat (18) cyc();
        bif.tick = 1'b0;
        chk("bottom_game_over", 32'(bif.game_over), 32'd1);
        chk("bottom_height", 32'(bif.lane_height[3:0]), 32'd9);
        chk("bottom_others_idle", 32'(bif.lane_value[23:8]), 32'd0);
        bif.tick = 1'b1;
        repeat (4) cyc();
        bif.tick = 1'b0;
        chk("bottom_game_over_held", 32'(bif.game_over), 32'd1);
        chk("bottom_height_held", 32'(bif.lane_height[3:0]), 32'd9);

        // Match on the very tick that would reach the bottom.
        do_reset();
        bif.reset_signal = 3'b001;
        cyc();
        bif.reset_signal = 3'b000;
        bif.tick = 1'b1;
        repeat (17) cyc();
        chk("edge_height8", 32'(bif.lane_height[3:0]), 32'd8);
        bif.switches = m_t[0];
        cyc();
        bif.tick = 1'b0;
        chk("edge_correct", 32'(bif.correct[0]), 32'd1);
        chk("edge_no_game_over", 32'(bif.game_over[0]), 32'd0);
        chk("edge_height_clear", 32'(bif.lane_height[3:0]), 32'd0);

        // Randomised play against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++)
                bif.reset_signal[i] = ($urandom_range(0, 39) == 0);
            bif.tick = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0)
                bif.switches = m_t[$urandom_range(0, 2)];
            else
                bif.switches = 8'($urandom);
            cyc();
        end
        reset = 1'b0;
        bif.reset_signal = 3'b000;
        bif.tick = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_bank.md
LANE_BANK -- requirements
Module: lane_bank

Interface
REQ-001 Parameter HEIGHT_MAX, default 9: lane height at which a falling target reaches the bottom.
REQ-002 Parameter SEED, default 8'hA5: LFSR value loaded on reset; SEED of 0 is illegal.
REQ-003 clock  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reset_signal  input  3  per-lane restart request from the game state machine; level-sensitive.
REQ-006 tick  input  1  one-cycle fall-step strobe.
REQ-007 switches  input  8  player switch value.
REQ-008 game_over  output  3  per-lane level; high while the lane is in OVER.
REQ-009 correct  output  3  per-lane one-cycle pulse on a match.
REQ-010 lane_value  output  24  current targets; lane i occupies bits [8i+7:8i].
REQ-011 lane_height  output  12  current heights; lane i occupies bits [4i+3:4i].

Function
REQ-012 Each lane is a state machine with states IDLE, FALL and OVER.
REQ-013 IDLE or OVER with reset_signal[i]=1: next state FALL, height 0, target loaded from the LFSR, game_over[i]=0.
REQ-014 FALL with reset_signal[i]=1: restart exactly as REQ-013.
REQ-015 FALL, advance strobe (REQ-026) and no match: height increments by 1.
REQ-016 FALL, height+1 equals HEIGHT_MAX on an advance: next state OVER, game_over[i]=1 on the following cycle.
REQ-017 FALL, switches equal the target: correct[i] pulses high for exactly 1 cycle (registered, 1-cycle latency), height clears to 0, new target loads, state stays FALL.
REQ-018 Match and bottom-reach in the same cycle: the match wins, so correct pulses and game_over stays 0.
REQ-019 reset_signal[i] and a match in the same cycle: the reset wins, so there is no correct pulse.
REQ-020 Multiple lanes matching the same switches in the same cycle: every matching lane pulses correct and reloads.
REQ-021 IDLE and OVER ignore switches and tick; height and target are held.
REQ-022 The LFSR is 8 bits, polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, and steps every clock.
REQ-023 Lanes loading in the same cycle take LFSR, LFSR rotated left 3, and LFSR rotated left 5 for lanes 0, 1 and 2.
REQ-024 A loaded target equal to the current switches is stored with bit 0 inverted, so there is never an immediate match.
REQ-025 Height is 4 bits and never exceeds HEIGHT_MAX; HEIGHT_MAX is at most 15.
REQ-026 Advance strobe with LANE_SPEEDUP_EN undefined: every second tick, counted per lane by a phase bit that clears on load.

Reset
REQ-027 reset=1: all lanes IDLE, game_over=0, correct=0, lane_value=0, lane_height=0, LFSR=SEED, per-lane phase and hit counters 0.
REQ-028 reset mid-fall aborts the fall with no correct or game_over pulse; reset has priority over all inputs.

Configuration
REQ-029 Macro LANE_SPEEDUP_EN defined: each lane keeps a saturating 3-bit hit count, cleared on restart and incremented on each correct.
REQ-030 With LANE_SPEEDUP_EN defined and the hit count at 4 or more, every tick advances the lane; below 4, the advance follows REQ-026.
REQ-031 Macro LANE_SPEEDUP_EN undefined: no hit counter is synthesised and REQ-026 applies unconditionally.

Structure
REQ-032 Package flippy_pkg holds the lane state enum (IDLE, FALL, OVER), the LANES=3 constant and the LFSR tap mask constant.
REQ-033 Sub-module lane_unit holds one lane's state machine, target, height, phase and hit counter; lane_bank instantiates 3 lane_unit instances plus the shared LFSR.

Verification
REQ-034 Stimulus: reset, then reset_signal=3'b001 for 1 cycle, then 18 ticks with switches=0 and no match. Response: lane 0 reaches OVER, game_over=3'b001 held; lanes 1 and 2 stay IDLE.
REQ-035 Stimulus: lane 1 in FALL, switches set to lane_value[15:8]. Response: correct=3'b010 for exactly 1 cycle, lane_height[7:4]=0, new target differs from switches.
REQ-036 Stimulus: lane 0 at height 8, tick on the second phase and matching switches in the same cycle. Response: correct[0] pulses, game_over[0]=0.
REQ-037 Stimulus: reset_signal=3'b100 and a lane-2 match in the same cycle. Response: no correct pulse; lane 2 restarts at height 0.
REQ-038 Stimulus: SEED=8'hA5, reset, then reset_signal=3'b111 on the first cycle after reset. Response: lane_value={ROL5(8'hA5), ROL3(8'hA5), 8'hA5} with REQ-024 applied against switches.
REQ-039 Stimulus: LANE_SPEEDUP_EN defined, 4 consecutive correct on lane 0. Response: afterwards height increments on every tick.
